// File: rtl/pwm_pkg.sv
// Shared types and helpers for the pwm_compare_nch slice.
// Optional polarity feature is selected with PWM_POLARITY_EN.
package pwm_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  function automatic int chan_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: duty shadow, committed duty, compare and output flop.
// With PWM_POLARITY_EN the channel also shadows/commits an output polarity bit.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         commit,
  input  logic         wr_hit,
  input  logic [N-1:0] wr_data,
  input  logic [N-1:0] cnt,
`ifdef PWM_POLARITY_EN
  input  logic         pol,
`endif
  output logic         pwm
);

  logic [N-1:0] duty_sh;
  logic [N-1:0] duty_act;
  logic         idle_lvl;
  logic         flip;

`ifdef PWM_POLARITY_EN
  logic pol_sh;
  logic pol_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_sh  <= 1'b0;
      pol_act <= 1'b0;
    end else begin
      pol_sh <= pol;
      if (commit) pol_act <= pol_sh;
    end
  end

  assign idle_lvl = pol_sh;
  assign flip     = pol_act;
`else
  assign idle_lvl = 1'b0;
  assign flip     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr_hit) duty_sh <= wr_data;
      // a write landing on the commit cycle is forwarded straight into the active copy
      if (commit) duty_act <= wr_hit ? wr_data : duty_sh;
      pwm <= en ? ((cnt < duty_act) ^ flip) : idle_lvl;
    end
  end

endmodule

// File: rtl/pwm_compare_nch.sv
// Shared period counter (edge/center aligned) driving CH duty comparators.
// Define PWM_POLARITY_EN to add the per-channel pol input.
module pwm_compare_nch
  import pwm_pkg::*;
#(
  parameter int N  = 7,
  parameter int CH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   center,
  input  logic [N-1:0]           period,
  input  logic                   wr_en,
  input  logic [chan_w(CH)-1:0]  wr_ch,
  input  logic [N-1:0]           wr_data,
`ifdef PWM_POLARITY_EN
  input  logic [CH-1:0]          pol,
`endif
  output logic [CH-1:0]          pwm,
  output logic                   sync,
  output logic                   pending,
  output logic [N-1:0]           cnt
);

  logic [N-1:0] period_sh;
  logic [N-1:0] period_act;
  logic         center_act;
  dir_t         dir;
  dir_t         dir_nx;
  logic [N-1:0] cnt_nx;
  logic         bnd;
  logic         commit;
  logic         wr_ok;

  assign wr_ok = wr_en && (int'(wr_ch) < CH);

  always_comb begin
    bnd    = 1'b0;
    commit = 1'b0;
    cnt_nx = cnt;
    dir_nx = dir;
    if (center_act == MODE_CENTER) bnd = ((cnt == '0) && (dir == DIR_DOWN)) || (period_act == '0);
    else                           bnd = (cnt == period_act);
    commit = !en || bnd;
    if (!en) begin
      cnt_nx = '0;
      dir_nx = DIR_UP;
    end else if (bnd) begin
      // center period ends on the single cnt==0 cycle, so the next one starts at 1
      dir_nx = DIR_UP;
      cnt_nx = ((center_act == MODE_CENTER) && (period_sh != '0)) ? N'(1) : '0;
    end else if (center_act == MODE_EDGE) begin
      cnt_nx = cnt + N'(1);
    end else begin
      case (dir)
        DIR_UP: begin
          if (cnt == period_act) begin
            dir_nx = DIR_DOWN;
            cnt_nx = cnt - N'(1);
          end else begin
            cnt_nx = cnt + N'(1);
          end
        end
        default: cnt_nx = cnt - N'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      dir        <= DIR_UP;
      period_sh  <= '0;
      period_act <= '0;
      center_act <= MODE_EDGE;
      sync       <= 1'b0;
      pending    <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      dir       <= dir_nx;
      period_sh <= period;
      if (commit) begin
        period_act <= period_sh;
        center_act <= center;
      end
      sync    <= en && bnd;
      pending <= en && !bnd && (pending || wr_ok);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_chan #(
      .N(N)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .commit  (commit),
      .wr_hit  (wr_ok && (int'(wr_ch) == i)),
      .wr_data (wr_data),
      .cnt     (cnt),
`ifdef PWM_POLARITY_EN
      .pol     (pol[i]),
`endif
      .pwm     (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_compare_nch.sv
// Bench for pwm_compare_nch: period-position reference model, directed literals, random run.
// A CH=3 instance shares the stimulus so that wr_ch=3 exercises the out-of-range path.
module tb_pwm_compare_nch;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       center;
  logic [6:0] period;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [6:0] wr_data;
  logic [3:0] pol;
  logic [3:0] pwm;
  logic       sync;
  logic       pending;
  logic [6:0] cnt;
  logic [2:0] pwm3;
  logic       sync3;
  logic       pending3;
  logic [6:0] cnt3;

`ifdef PWM_POLARITY_EN
  localparam logic [3:0] POL_MASK = 4'hF;
`else
  localparam logic [3:0] POL_MASK = 4'h0;
`endif

  pwm_compare_nch #(.N(7), .CH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .center(center), .period(period),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
`ifdef PWM_POLARITY_EN
    .pol(pol),
`endif
    .pwm(pwm), .sync(sync), .pending(pending), .cnt(cnt)
  );

  pwm_compare_nch #(.N(7), .CH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .center(center), .period(period),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
`ifdef PWM_POLARITY_EN
    .pol(pol[2:0]),
`endif
    .pwm(pwm3), .sync(sync3), .pending(pending3), .cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: position within the current period; cnt is derived from it.
  int         m_pos, m_p, m_psh;
  bit         m_ctr;
  int         m_dsh[4];
  int         m_dact[4];
  bit [3:0]   m_polsh, m_polact, e_pwm;
  bit         e_sync, e_pend, e_pend3;

  function automatic int cnt_of(input int pos, input int p, input bit ctr);
    return (ctr && pos > p) ? 2 * p - pos : pos;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_p = 0; m_psh = 0; m_ctr = 1'b0;
      for (int i = 0; i < 4; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
      m_polsh = '0; m_polact = '0; e_pwm = '0;
      e_sync = 1'b0; e_pend = 1'b0; e_pend3 = 1'b0;
    end else begin
      int c;
      bit last;
      bit old_ctr;
      int fwd[4];
      c = cnt_of(m_pos, m_p, m_ctr);
      old_ctr = m_ctr;
      for (int i = 0; i < 4; i++) fwd[i] = (wr_en && int'(wr_ch) == i) ? int'(wr_data) : m_dsh[i];
      if (!en) begin
        e_pwm = m_polsh; e_sync = 1'b0; e_pend = 1'b0; e_pend3 = 1'b0;
        last = 1'b1;
      end else begin
        last = m_ctr ? (m_pos == 2 * m_p || m_p == 0) : (m_pos == m_p);
        for (int i = 0; i < 4; i++) e_pwm[i] = (c < m_dact[i]) ^ m_polact[i];
        e_sync = last;
        if (last) begin
          e_pend = 1'b0; e_pend3 = 1'b0;
        end else begin
          e_pend  = e_pend | wr_en;
          e_pend3 = e_pend3 | (wr_en && wr_ch < 2'd3);
        end
      end
      if (last) begin
        if (!en) m_pos = 0;
        else     m_pos = (old_ctr && m_psh != 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) m_dact[i] = fwd[i];
        m_p = m_psh; m_ctr = center; m_polact = m_polsh;
      end else begin
        m_pos++;
      end
      for (int i = 0; i < 4; i++) m_dsh[i] = fwd[i];
      m_psh = int'(period);
      m_polsh = pol & POL_MASK;
    end
  end

  always @(negedge clk) begin
    chk("cnt", 32'(cnt), 32'(cnt_of(m_pos, m_p, m_ctr)));
    chk("pwm", 32'(pwm), 32'(e_pwm));
    chk("sync", 32'(sync), 32'(e_sync));
    chk("pending", 32'(pending), 32'(e_pend));
    chk("cnt3", 32'(cnt3), 32'(cnt_of(m_pos, m_p, m_ctr)));
    chk("pwm3", 32'(pwm3), 32'(e_pwm[2:0]));
    chk("sync3", 32'(sync3), 32'(e_sync));
    chk("pending3", 32'(pending3), 32'(e_pend3));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [6:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int k;
    k = 0;
    while (cnt_of(m_pos, m_p, m_ctr) != target && k < 100) begin
      step(1);
      k++;
    end
    if (k >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL wait_cnt: timeout waiting for cnt %0d", target);
    end
  endtask

  int h0, h1, h2, h3, hs, hp;
  task automatic run_count(input int n);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0; hs = 0; hp = 0;
    repeat (n) begin
      @(posedge clk); #3;
      h0 += int'(pwm[0]); h1 += int'(pwm[1]); h2 += int'(pwm[2]); h3 += int'(pwm[3]);
      hs += int'(sync); hp += int'(pending);
    end
  endtask

  int seq[11] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2};

  initial begin
    rst_n = 1'b0; en = 1'b0; center = 1'b0; period = '0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0; pol = '0;
    #3;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_sync", 32'(sync), 0);
    step(2);
    rst_n = 1'b1; period = 7'd9;
    wr(2'd0, 7'd3);
    step(3);
    en = 1'b1;
    step(12);
    run_count(20);
    chk("edge_duty3_high", h0, 6);
    chk("edge_sync_count", hs, 2);

    wait_cnt(3);
    wr(2'd1, 7'd5);
    #2;
    chk("mid_write_pending", 32'(pending), 1);
    chk("mid_write_pwm1_unchanged", 32'(pwm[1]), 0);
    step(10);
    run_count(20);
    chk("duty5_high", h1, 10);
    chk("pending_after_commit", hp, 0);

    wait_cnt(9);
    wr(2'd2, 7'd7);
    run_count(20);
    chk("coincident_pending", hp, 0);
    chk("coincident_duty7_high", h2, 14);

    wr(2'd1, 7'd10);
    step(12);
    run_count(20);
    chk("duty_over_period_high", h1, 20);
    chk("duty_zero_high", h3, 0);

    en = 1'b0; center = 1'b1; period = 7'd4;
    wr(2'd0, 7'd2);
    step(3);
    en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      chk("center_cnt_seq", 32'(cnt), 32'(seq[k]));
      step(1);
    end
    run_count(16);
    chk("center_duty2_high", h0, 6);

    center = 1'b0; period = 7'd0;
    step(20);
    run_count(5);
    chk("period0_sync", hs, 5);

    period = 7'd9;
    step(30);
    wait_cnt(4);
    wr(2'd3, 7'd9);
    #2;
    chk("oor_pending_ch3", 32'(pending3), 0);
    chk("inrange_pending_ch4", 32'(pending), 1);

    en = 1'b0;
    step(1); #2;
    chk("en_low_cnt", 32'(cnt), 0);
    chk("en_low_pwm", 32'(pwm), 0);
    chk("en_low_pending", 32'(pending), 0);
    pol = 4'b0101;
    step(2); #2;
    chk("idle_level", 32'(pwm), 32'(4'b0101 & POL_MASK));
    pol = '0; en = 1'b1;
    step(6);
    wr(2'd0, 7'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(cnt), 0);
    chk("mid_rst_pwm", 32'(pwm), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    step(2);
    rst_n = 1'b1;

    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom_range(99) != 0);
      en = ($urandom_range(19) != 0);
      if ($urandom_range(49) == 0) center = ~center;
      if ($urandom_range(39) == 0) period = 7'($urandom_range(12));
      wr_en = ($urandom_range(2) == 0);
      wr_ch = 2'($urandom);
      wr_data = ($urandom_range(7) == 0) ? 7'($urandom) : 7'($urandom_range(14));
      if ($urandom_range(63) == 0) pol = 4'($urandom);
      step(1);
    end
    rst_n = 1'b1; wr_en = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
